button_debounce: RTL
====================

// Module: button_debounce
//
// PURPOSE
//   Conditions a raw mechanical push-button input for board demo designs.
//   Provides a 2-FF synchronizer, a debounce state machine, a clean level
//   output, and single-cycle press/release/short/long event pulses.
//   Sits between the button pin and the demo logic that consumes button state
//   (blink-rate selection, mode stepping).
//
// PARAMETERS
//   DEBOUNCE_CYCLES  250000    consecutive stable samples to accept a change (>=2; 10 ms @ 25 MHz)
//   LONG_CYCLES      25000000  hold time in clocks after acceptance for long_o (>=1; 1 s @ 25 MHz)
//   ACTIVE_LOW       1         1: pin reads 0 when pressed (pull-up); 0: pin reads 1 when pressed
//
// PORTS
//   clk_i      in   1  system clock; sole clock domain
//   rst_i      in   1  asynchronous, active-high reset
//   button_i   in   1  raw button pin; asynchronous to clk_i
//   pressed_o  out  1  debounced level; 1 = pressed
//   press_o    out  1  1-cycle pulse when a press is accepted
//   release_o  out  1  1-cycle pulse when a release is accepted
//   short_o    out  1  1-cycle pulse on release if long_o did not fire in this press
//   long_o     out  1  1-cycle pulse when the hold reaches LONG_CYCLES; at most once per press
//
// BEHAVIOUR
//   - Clocking: one clock, clk_i.
//   - Reset: rst_i is asynchronous and active-high.
//   - Outputs: all registered; all outputs reset to 0.
//   - Synchronizer:
//       Two FFs; both reset to the released level.
//       Normalized level p = synchronizer output XOR ACTIVE_LOW (1 = pressed).
//   - Counters: unsaturated width $clog2(max+1).
//       dcnt: debounce counter.
//       hcnt: hold counter; saturates at LONG_CYCLES.
//   - FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Reset state is IDLE.
//   - IDLE:
//       p=1 -> PRESS_WAIT, dcnt<=1.
//   - PRESS_WAIT:
//       p=0 -> IDLE (bounce rejected, no pulse).
//       p=1 and dcnt==DEBOUNCE_CYCLES-1 -> HELD; pressed_o<=1, press_o<=1 for 1 cycle, hcnt<=0.
//       Otherwise dcnt++.
//   - HELD:
//       hcnt++ until saturated.
//       long_o pulses on the edge where hcnt goes LONG_CYCLES-1 -> LONG_CYCLES.
//       p=0 -> RELEASE_WAIT, dcnt<=1.
//   - RELEASE_WAIT:
//       hcnt keeps counting; long_o can still fire in this state.
//       p=1 -> HELD (glitch rejected; hcnt not cleared, no pulse).
//       p=0 and dcnt==DEBOUNCE_CYCLES-1 -> IDLE; pressed_o<=0, release_o<=1,
//         and short_o<=1 iff hcnt<LONG_CYCLES.
//       Otherwise dcnt++.
//   - Latency: a clean raw edge before clock edge 0 changes pressed_o and pulses
//     press_o/release_o after edge DEBOUNCE_CYCLES+1.
//       Long press: long_o fires LONG_CYCLES edges after press_o.
//   - Boundaries:
//       Any p change during a *_WAIT state restarts from the stable state; there is no partial credit.
//       If the long threshold and release acceptance land on the same edge, long_o and
//         release_o pulse together and short_o stays 0.
//       Reset mid-press returns to IDLE with no release pulse. A button still held after
//         reset is re-debounced and produces press_o.
//       Event pulses are never wider than 1 cycle. Consecutive presses may be spaced
//         2*DEBOUNCE_CYCLES apart.
//
// STRUCTURE
//   - No shared package. State encoding is localparams private to this module.
//   - One sub-module, sync_2ff: two-flop synchronizer with a reset-value parameter,
//     reusable for other pin inputs.
//
// TESTING  (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1)
//   1. Reset with button_i=1 -> all outputs 0 for 10 cycles.
//   2. Clean press: button_i 1->0 before edge 0 -> pressed_o=1 and 1-cycle press_o after edge 5.
//        Release after 10 held cycles -> release_o+short_o pulse 5 edges later; long_o never fires.
//   3. Bounce: pulse button_i low 3 cycles, high 2, repeated 5 times, then high -> no pulses,
//        pressed_o stays 0.
//   4. Long hold: press and hold 40 cycles -> long_o 1 cycle exactly 20 edges after press_o.
//        Release -> release_o only, short_o=0.
//   5. Release glitch: while HELD, drive 1 for 2 cycles then 0 -> pressed_o stays 1, no release_o,
//        hcnt uninterrupted.
//   6. Assert rst_i mid-HELD with button still pressed -> outputs 0 immediately.
//        After deassert, press_o fires again after edge 5.

Source files
------------

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin.
// RESET_VALUE lets each pin start at its own idle level so that leaving
// reset never looks like an input transition.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_reg;
    logic sync_reg;

    // Capture the raw pin, then retime once more to let metastability settle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_reg <= RESET_VALUE;
            sync_reg <= RESET_VALUE;
        end else begin
            meta_reg <= d_i;
            sync_reg <= meta_reg;
        end
    end

    assign q_o = sync_reg;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronizes the pin, debounces it with a
// four-state FSM and produces a clean level plus one-cycle press, release,
// short-press and long-press pulses. All outputs are registered.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic button_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic long_o
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HCNT_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
    localparam logic [HCNT_W-1:0] HCNT_PRE  = HCNT_W'(LONG_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(LONG_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT
    } state_t;

    state_t            state_reg,   state_next;
    logic [DCNT_W-1:0] dcnt_reg,    dcnt_next;
    logic [HCNT_W-1:0] hcnt_reg,    hcnt_next;
    logic              pressed_reg, pressed_next;
    logic              press_reg,   press_next;
    logic              release_reg, release_next;
    logic              short_reg,   short_next;
    logic              long_reg,    long_next;

    logic pin_sync;
    logic p;            // 1 = button pressed, independent of pin polarity
    logic hold_active;  // hold timer runs while the press is accepted

    // The released level is 1 for a pull-up button, 0 otherwise.
    sync_2ff #(
        .RESET_VALUE (ACTIVE_LOW)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (button_i),
        .q_o   (pin_sync)
    );

    assign p           = pin_sync ^ ACTIVE_LOW;
    assign hold_active = (state_reg == ST_HELD) || (state_reg == ST_RELEASE_WAIT);

    // Next-state logic: debounce FSM, hold timer and event pulses.
    always_comb begin
        state_next   = state_reg;
        dcnt_next    = dcnt_reg;
        hcnt_next    = hcnt_reg;
        pressed_next = pressed_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        short_next   = 1'b0;
        long_next    = 1'b0;

        // The hold timer keeps running through release glitches; it only
        // fires long once because it saturates at the threshold.
        if (hold_active && (hcnt_reg != HCNT_MAX)) begin
            hcnt_next = hcnt_reg + HCNT_ONE;
            if (hcnt_reg == HCNT_PRE) begin
                long_next = 1'b1;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (p) begin
                    state_next = ST_PRESS_WAIT;
                    dcnt_next  = DCNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!p) begin
                    state_next = ST_IDLE;
                end else if (dcnt_reg == DCNT_LAST) begin
                    state_next   = ST_HELD;
                    pressed_next = 1'b1;
                    press_next   = 1'b1;
                    hcnt_next    = '0;
                end else begin
                    dcnt_next = dcnt_reg + DCNT_ONE;
                end
            end
            ST_HELD: begin
                if (!p) begin
                    state_next = ST_RELEASE_WAIT;
                    dcnt_next  = DCNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (p) begin
                    state_next = ST_HELD;
                end else if (dcnt_reg == DCNT_LAST) begin
                    state_next   = ST_IDLE;
                    pressed_next = 1'b0;
                    release_next = 1'b1;
                    // Judge against the updated timer so a long pulse on this
                    // same edge suppresses short.
                    short_next   = (hcnt_next < HCNT_MAX);
                end else begin
                    dcnt_next = dcnt_reg + DCNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops to idle with all outputs low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            dcnt_reg    <= '0;
            hcnt_reg    <= '0;
            pressed_reg <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            short_reg   <= 1'b0;
            long_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dcnt_reg    <= dcnt_next;
            hcnt_reg    <= hcnt_next;
            pressed_reg <= pressed_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            short_reg   <= short_next;
            long_reg    <= long_next;
        end
    end

    assign pressed_o = pressed_reg;
    assign press_o   = press_reg;
    assign release_o = release_reg;
    assign short_o   = short_reg;
    assign long_o    = long_reg;

endmodule
